sobel_stream_pipe: RTL and testbench

// Parametrised streaming Sobel edge stage for the edge-detection datapath. Sits between the pixel source and the

---
 rtl/sobel_stream_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_sobel_stream_pipe.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_pipe.sv
// Streaming 3x3 Sobel edge stage: two line buffers, |Gx|+|Gy|, shift and saturate, valid/sof/eol framing.
// Define EDGE_THRESH_EN to binarise the output against thresh (default build passes the saturated magnitude).
module sobel_stream_pipe #(
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 256,
    parameter int unsigned IMG_H = 256,
    parameter int unsigned SHIFT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] thresh,
    output logic          out_valid,
    output logic          out_sof,
    output logic          out_eol,
    output logic [DW-1:0] out_data,
    output logic          frame_err
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned GW = DW + 3;
    localparam int unsigned MW = DW + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d, pcol_c;
    logic [RW-1:0] row_q, row_d, prow_c;
    logic          err_d, acc_c;

    // Frame tracking: decides acceptance and the (row, col) of the accepted pixel
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        err_d   = frame_err;
        acc_c   = 1'b0;
        pcol_c  = col_q;
        prow_c  = row_q;
        if (in_valid) begin
            if (in_sof) begin
                acc_c  = 1'b1;
                pcol_c = '0;
                prow_c = '0;
                err_d  = (state_q == RUN);
            end else if (state_q == RUN) begin
                acc_c = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (acc_c) begin
            state_d = RUN;
            if (pcol_c == COL_LAST) begin
                col_d = '0;
                if (prow_c == ROW_LAST) begin
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    row_d = prow_c + RW'(1);
                end
            end else begin
                col_d = pcol_c + CW'(1);
                row_d = prow_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            frame_err <= err_d;
        end
    end

    // Accepted-pixel capture with precomputed window tags
    logic          q_v, q_win, q_sof, q_eol;
    logic [DW-1:0] q_pix;
    logic [CW-1:0] q_col;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_v   <= 1'b0;
            q_win <= 1'b0;
            q_sof <= 1'b0;
            q_eol <= 1'b0;
            q_pix <= '0;
            q_col <= '0;
        end else begin
            q_v <= acc_c;
            if (acc_c) begin
                q_pix <= in_data;
                q_col <= pcol_c;
                q_win <= (prow_c >= RW'(2)) && (pcol_c >= CW'(2));
                q_sof <= (prow_c == RW'(2)) && (pcol_c == CW'(2));
                q_eol <= (pcol_c == COL_LAST);
            end
        end
    end

    // S1: line buffers (row-1 in lb1, row-2 in lb2) and the 3x3 window, shifted per pixel
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] lb2 [IMG_W];
    logic [DW-1:0] win [3][3];

    always_ff @(posedge clk) begin
        if (q_v) begin
            lb1[q_col] <= q_pix;
            lb2[q_col] <= lb1[q_col];
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb2[q_col];
            win[1][2] <= lb1[q_col];
            win[2][2] <= q_pix;
        end
    end

    // S2: Gx/Gy as differences of weighted column/row sums
    logic [GW-1:0]        xp_c, xn_c, yp_c, yn_c;
    logic signed [GW-1:0] gx_q, gy_q;

    always_comb begin
        xp_c = GW'(win[0][2]) + GW'(win[1][2]) + GW'(win[1][2]) + GW'(win[2][2]);
        xn_c = GW'(win[0][0]) + GW'(win[1][0]) + GW'(win[1][0]) + GW'(win[2][0]);
        yp_c = GW'(win[2][0]) + GW'(win[2][1]) + GW'(win[2][1]) + GW'(win[2][2]);
        yn_c = GW'(win[0][0]) + GW'(win[0][1]) + GW'(win[0][1]) + GW'(win[0][2]);
    end

    always_ff @(posedge clk) begin
        gx_q <= $signed(xp_c - xn_c);
        gy_q <= $signed(yp_c - yn_c);
    end

    // S3: magnitude
    logic [GW-1:0] ax_c, ay_c;
    logic [MW-1:0] mag_q;

    always_comb begin
        ax_c = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
        ay_c = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    end

    always_ff @(posedge clk) begin
        mag_q <= MW'(ax_c) + MW'(ay_c);
    end

    // S4: scale, saturate, optional binarisation
    logic [MW-1:0] m_c;
    logic [DW-1:0] sat_c, res_c;

    always_comb begin
        m_c   = mag_q >> SHIFT;
        sat_c = (|m_c[MW-1:DW]) ? {DW{1'b1}} : m_c[DW-1:0];
`ifdef EDGE_THRESH_EN
        res_c = (sat_c >= thresh) ? {DW{1'b1}} : {DW{1'b0}};
`else
        res_c = sat_c;
`endif
    end

`ifndef EDGE_THRESH_EN
    logic unused_thresh;
    assign unused_thresh = ^thresh;
`endif

    // Valid/framing tags travel alongside the datapath, one register per stage
    logic v1, s1, e1, v2, s2, e2, v3, s3, e3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1        <= 1'b0;
            s1        <= 1'b0;
            e1        <= 1'b0;
            v2        <= 1'b0;
            s2        <= 1'b0;
            e2        <= 1'b0;
            v3        <= 1'b0;
            s3        <= 1'b0;
            e3        <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_data  <= '0;
        end else begin
            v1        <= q_v & q_win;
            s1        <= q_v & q_sof;
            e1        <= q_v & q_win & q_eol;
            v2        <= v1;
            s2        <= s1;
            e2        <= e1;
            v3        <= v2;
            s3        <= s2;
            e3        <= e2;
            out_valid <= v3;
            out_sof   <= s3;
            out_eol   <= e3;
            if (v3) begin
                out_data <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_pipe.sv
// Bench for sobel_stream_pipe: two instances (SHIFT=3 and SHIFT=0) on an 8x8 image against an arithmetic reference.
module tb_sobel_stream_pipe;

    localparam int W = 8;
    localparam int H = 8;
    localparam logic [7:0] THR = 8'h80;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  d3;
        logic [7:0]  d0;
        logic        v0;
        logic        sof;
        logic        eol;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_sof;
    logic [7:0] in_data, thresh;
    logic       ov3, os3, oe3, fe3;
    logic [7:0] od3;
    logic       ov0, os0, oe0, fe0;
    logic [7:0] od0;

    ev_t         got[$];
    ev_t         exp[$];
    ev_t         mon_e;
    int          img[H][W];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sobel_stream_pipe #(.DW(8), .IMG_W(W), .IMG_H(H), .SHIFT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data), .thresh(thresh),
        .out_valid(ov3), .out_sof(os3), .out_eol(oe3), .out_data(od3), .frame_err(fe3)
    );

    sobel_stream_pipe #(.DW(8), .IMG_W(W), .IMG_H(H), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data), .thresh(thresh),
        .out_valid(ov0), .out_sof(os0), .out_eol(oe0), .out_data(od0), .frame_err(fe0)
    );

    // Output recorder
    always @(negedge clk) begin
        if (ov3 === 1'b1) begin
            mon_e.cyc = cyc;
            mon_e.d3  = od3;
            mon_e.d0  = od0;
            mon_e.v0  = ov0;
            mon_e.sof = os3;
            mon_e.eol = oe3;
            got.push_back(mon_e);
        end
    end

    function automatic logic [7:0] ref_px(input int r, input int c, input int sh);
        int p[3][3];
        int gx, gy, m;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[r-2+i][c-2+j];
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        m  = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> sh;
        if (m > 255) m = 255;
`ifdef EDGE_THRESH_EN
        m = (m >= int'(THR)) ? 255 : 0;
`endif
        return 8'(m);
    endfunction

    function automatic void fill_img(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0:       img[r][c] = 128;
                    1:       img[r][c] = (c >= 4) ? 255 : 0;
                    2:       img[r][c] = (c > r) ? 255 : 0;
                    3:       img[r][c] = (((r >> 1) + (c >> 1)) & 1) ? 255 : 0;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
    endfunction

    // Drives the first n_pix pixels of img (sof on the first) and queues the expected outputs
    task automatic send_frame(input int n_pix, input int gap_pct);
        ev_t e;
        int  r, c;
        for (int k = 0; k < n_pix; k++) begin
            r = k / W;
            c = k % W;
            if ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_sof   = (k == 0);
            in_data  = 8'(img[r][c]);
            @(negedge clk);
            if (r >= 2 && c >= 2) begin
                e.cyc = cyc + 4;
                e.d3  = ref_px(r, c, 3);
                e.d0  = ref_px(r, c, 0);
                e.v0  = 1'b1;
                e.sof = (r == 2 && c == 2);
                e.eol = (c == W - 1);
                exp.push_back(e);
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({ov3, os3, oe3, od3, fe3} !== 12'h0) begin
            errors++;
            $display("FAIL reset_dut3 got=%h exp=0", {ov3, os3, oe3, od3, fe3});
        end
        checks++;
        if ({ov0, os0, oe0, od0, fe0} !== 12'h0) begin
            errors++;
            $display("FAIL reset_dut0 got=%h exp=0", {ov0, os0, oe0, od0, fe0});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ov3, fe3, got.size()} !== {1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_idle got valid=%b err=%b outs=%0d exp 0 0 0", ov3, fe3, got.size());
        end
    endtask

    task automatic test_flat();
        int nsof = 0, neol = 0;
        fill_img(0);
        send_frame(W * H, 0);
        drain();
        checks++;
        if (got.size() != 36 || exp.size() != 36) begin
            errors++;
            $display("FAIL flat_count got=%0d exp=36 (model %0d)", got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL flat_out[%0d] got=%h exp=%h", i, got[i], exp[i]);
            end
            checks++;
            if (got[i].d3 !== 8'h00) begin
                errors++;
                $display("FAIL flat_zero[%0d] got=%h exp=00", i, got[i].d3);
            end
            nsof += int'(got[i].sof);
            neol += int'(got[i].eol);
        end
        checks++;
        if (nsof != 1 || neol != 6) begin
            errors++;
            $display("FAIL flat_framing got sof=%0d eol=%0d exp sof=1 eol=6", nsof, neol);
        end
        checks++;
        if (fe3 !== 1'b0) begin
            errors++;
            $display("FAIL flat_err got=%b exp=0", fe3);
        end
        got.delete();
        exp.delete();
    endtask

    task automatic test_pattern(input int kind, input string name);
        int n7f = 0;
        fill_img(kind);
        send_frame(W * H, 0);
        drain();
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL %s_out[%0d] got=%h exp=%h", name, i, got[i], exp[i]);
            end
            if (got[i].d3 == 8'h7F) n7f++;
        end
`ifndef EDGE_THRESH_EN
        if (kind == 1) begin
            checks++;
            if (n7f != 12) begin
                errors++;
                $display("FAIL vstep_7f_count got=%0d exp=12", n7f);
            end
        end
`endif
        got.delete();
        exp.delete();
    endtask

    task automatic test_gaps();
        fill_img(4);
        send_frame(W * H, 50);
        drain();
        checks++;
        if (got.size() != 36) begin
            errors++;
            $display("FAIL gaps_count got=%0d exp=36", got.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL gaps_out[%0d] got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        got.delete();
        exp.delete();
    endtask

    task automatic test_back_to_back();
        fill_img(4);
        send_frame(W * H, 0);
        fill_img(4);
        send_frame(W * H, 0);
        drain();
        checks++;
        if (got.size() != 72) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=72", got.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_out[%0d] got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (fe3 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err got=%b exp=0", fe3);
        end
        got.delete();
        exp.delete();
    endtask

    task automatic test_idle_drop();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_sof   = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (fe3 !== 1'b1 || got.size() != 0) begin
            errors++;
            $display("FAIL drop_err got err=%b outs=%0d exp err=1 outs=0", fe3, got.size());
        end
        fill_img(4);
        send_frame(W * H, 30);
        drain();
        checks++;
        if (fe3 !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear got=%b exp=0", fe3);
        end
        checks++;
        if (got.size() != 36) begin
            errors++;
            $display("FAIL drop_count got=%0d exp=36", got.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL drop_out[%0d] got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        got.delete();
        exp.delete();
    endtask

    task automatic test_midframe_sof();
        fill_img(4);
        send_frame(3 * W + 4, 0);
        fill_img(4);
        send_frame(W * H, 20);
        drain();
        checks++;
        if (got.size() != 44) begin
            errors++;
            $display("FAIL midsof_count got=%0d exp=44", got.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL midsof_out[%0d] got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (fe3 !== 1'b1) begin
            errors++;
            $display("FAIL midsof_err got=%b exp=1", fe3);
        end
        got.delete();
        exp.delete();
    endtask

    task automatic test_reset_mid();
        fill_img(4);
        send_frame(5 * W + 2, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({ov3, os3, oe3, od3, fe3, ov0, od0} !== 21'h0) begin
            errors++;
            $display("FAIL rstmid_async got=%h exp=0", {ov3, os3, oe3, od3, fe3, ov0, od0});
        end
        repeat (2) @(negedge clk);
        got.delete();
        exp.delete();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_sof   = 1'b0;
            in_data  = 8'hFF;
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (got.size() != 0 || fe3 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle got outs=%0d err=%b exp outs=0 err=1", got.size(), fe3);
        end
        got.delete();
        fill_img(4);
        send_frame(W * H, 0);
        drain();
        checks++;
        if (got.size() != 36) begin
            errors++;
            $display("FAIL rstmid_count got=%0d exp=36", got.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL rstmid_out[%0d] got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        got.delete();
        exp.delete();
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
        thresh   = THR;
        repeat (3) @(negedge clk);
        test_reset();
        test_flat();
        test_pattern(1, "vstep");
        test_pattern(2, "diag");
        test_pattern(3, "checker");
        test_gaps();
        test_back_to_back();
        test_idle_drop();
        test_midframe_sof();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
